// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, STATUS bit indices and FSM state types for wb_uart.
package uart_pkg;

  localparam int CLKDIV_W = 16;
  localparam int STATUS_W = 7;

  // Register offsets, decoded from adr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLKDIV = 2'd2;

  // STATUS bit indices
  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_EMPTY   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_FRAME_ERR  = 5;
  localparam int ST_TX_BUSY    = 6;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: 8-bit synchronous FIFO; a push into a full FIFO succeeds when a pop
// happens in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic          do_push_s;
  logic          do_pop_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == DEPTH_C);
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign rdata_o   = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push_s) wptr_q <= wptr_q + AW'(1'b1);
      if (do_pop_s)  rptr_q <= rptr_q + AW'(1'b1);
      count_q <= count_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end
  end

  // Storage array; contents are only observed while the FIFO is non-empty
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/wb_uart.sv
// wb_uart: Wishbone slave 8N1 UART with TX/RX FIFOs, programmable bit period
// (CLKDIV+1 cycles) and sticky overrun / framing error flags.
module wb_uart
  import uart_pkg::*;
#(
  parameter int                  FIFO_DEPTH    = 4,
  parameter logic [CLKDIV_W-1:0] CLK_DIV_RESET = 16'd867
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [27:0] wb_adr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_ack_o,
  output logic        wb_error_o,
  output logic        wb_stall_o,
  output logic [31:0] wb_data_o,
  input  logic        uart_rx,
  output logic        uart_tx
);

  logic                req_s, ack_d, ack_q, err_d, err_q;
  logic [31:0]         rdata_d, rdata_q;
  logic [CLKDIV_W-1:0] clkdiv_d, clkdiv_q, clkdiv_wr_s;
  logic                ovr_d, ovr_q, fe_d, fe_q, clr_ovr_s, clr_fe_s, ovr_evt_s, fe_evt_s;
  logic [STATUS_W-1:0] status_s;
  logic                tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic                rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic [7:0]          tx_rdata_s, rx_rdata_s;

  tx_state_t           tx_state_d, tx_state_q;
  logic [CLKDIV_W-1:0] tx_timer_d, tx_timer_q;
  logic [2:0]          tx_bit_d, tx_bit_q;
  logic [7:0]          tx_shift_d, tx_shift_q;
  logic                tx_d, tx_q;

  rx_state_t           rx_state_d, rx_state_q;
  logic [CLKDIV_W-1:0] rx_timer_d, rx_timer_q, half_s;
  logic [CLKDIV_W:0]   half_sum_s;
  logic [2:0]          rx_bit_d, rx_bit_q;
  logic [7:0]          rx_shift_d, rx_shift_q;
  logic [1:0]          sync_q;
  logic                rx_prev_q, rx_s;

  assign req_s      = wb_cyc_i & wb_stb_i;
  assign wb_stall_o = 1'b0;
  assign wb_ack_o   = ack_q;
  assign wb_error_o = err_q;
  assign wb_data_o  = rdata_q;
  assign uart_tx    = tx_q;
  assign rx_s       = sync_q[1];
  // Mid-bit sample offset for the start bit: (CLKDIV+1)/2 cycles after the edge
  assign half_sum_s = {1'b0, clkdiv_q} + 17'd1;
  assign half_s     = half_sum_s[CLKDIV_W:1] - 16'd1;
  // A new error in the same cycle as a W1C clear keeps the flag set
  assign ovr_evt_s  = rx_push_s & rx_full_s & ~rx_pop_s;
  assign ovr_d      = (ovr_q & ~clr_ovr_s) | ovr_evt_s;
  assign fe_d       = (fe_q & ~clr_fe_s) | fe_evt_s;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(wb_clk_i), .rst_ni(wb_rst_n), .push_i(tx_push_s), .wdata_i(wb_data_i[7:0]),
    .pop_i(tx_pop_s), .rdata_o(tx_rdata_s), .full_o(tx_full_s), .empty_o(tx_empty_s)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(wb_clk_i), .rst_ni(wb_rst_n), .push_i(rx_push_s), .wdata_i(rx_shift_d),
    .pop_i(rx_pop_s), .rdata_o(rx_rdata_s), .full_o(rx_full_s), .empty_o(rx_empty_s)
  );

  // STATUS register image
  always_comb begin
    status_s                = '0;
    status_s[ST_TX_FULL]    = tx_full_s;
    status_s[ST_TX_EMPTY]   = tx_empty_s;
    status_s[ST_RX_EMPTY]   = rx_empty_s;
    status_s[ST_RX_FULL]    = rx_full_s;
    status_s[ST_RX_OVERRUN] = ovr_q;
    status_s[ST_FRAME_ERR]  = fe_q;
    status_s[ST_TX_BUSY]    = (tx_state_q != TX_IDLE);
  end

  // Bus decode: one response per accepted request, side effects on the accepting edge
  always_comb begin
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = 32'd0;
    tx_push_s   = 1'b0;
    rx_pop_s    = 1'b0;
    clr_ovr_s   = 1'b0;
    clr_fe_s    = 1'b0;
    clkdiv_wr_s = clkdiv_q;
    clkdiv_d    = clkdiv_q;
    if (req_s) begin
      ack_d = 1'b1;
      case (wb_adr_i[3:2])
        REG_DATA: begin
          if (wb_we_i) begin
            if (!wb_sel_i[0]) begin
              tx_push_s = 1'b0;
            end else if (tx_full_s && !tx_pop_s) begin
              ack_d = 1'b0;
              err_d = 1'b1;
            end else begin
              tx_push_s = 1'b1;
            end
          end else if (!rx_empty_s) begin
            rx_pop_s = 1'b1;
            rdata_d  = {23'd0, 1'b1, rx_rdata_s};
          end else begin
            rdata_d = 32'd0;
          end
        end
        REG_STATUS: begin
          if (wb_we_i && wb_sel_i[0]) begin
            clr_ovr_s = wb_data_i[ST_RX_OVERRUN];
            clr_fe_s  = wb_data_i[ST_FRAME_ERR];
          end else if (!wb_we_i) begin
            rdata_d = {25'd0, status_s};
          end else begin
            rdata_d = 32'd0;
          end
        end
        REG_CLKDIV: begin
          if (wb_we_i) begin
            if (wb_sel_i[0]) clkdiv_wr_s[7:0]  = wb_data_i[7:0];
            else             clkdiv_wr_s[7:0]  = clkdiv_q[7:0];
            if (wb_sel_i[1]) clkdiv_wr_s[15:8] = wb_data_i[15:8];
            else             clkdiv_wr_s[15:8] = clkdiv_q[15:8];
            clkdiv_d = (clkdiv_wr_s == 16'd0) ? 16'd1 : clkdiv_wr_s;
          end else begin
            rdata_d = {16'd0, clkdiv_q};
          end
        end
        default: begin
          ack_d = 1'b0;
          err_d = 1'b1;
        end
      endcase
    end else begin
      ack_d = 1'b0;
    end
  end

  // Bus response, configuration and sticky flag registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      clkdiv_q <= CLK_DIV_RESET;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      clkdiv_q <= clkdiv_d;
      ovr_q    <= ovr_d;
      fe_q     <= fe_d;
    end
  end

  // TX FSM next state; the serial line is registered from the current state
  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = tx_timer_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop_s   = 1'b0;
    tx_d       = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty_s) begin
          tx_pop_s   = 1'b1;
          tx_shift_d = tx_rdata_s;
          tx_timer_d = clkdiv_q;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        tx_d = 1'b0;
        if (tx_timer_q == 16'd0) begin
          tx_timer_d = clkdiv_q;
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_timer_d = tx_timer_q - 16'd1;
        end
      end
      TX_DATA: begin
        tx_d = tx_shift_q[0];
        if (tx_timer_q == 16'd0) begin
          tx_timer_d = clkdiv_q;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_state_d = TX_DATA;
        end else begin
          tx_timer_d = tx_timer_q - 16'd1;
        end
      end
      TX_STOP: begin
        tx_d = 1'b1;
        if (tx_timer_q != 16'd0) begin
          tx_timer_d = tx_timer_q - 16'd1;
        end else if (!tx_empty_s) begin
          tx_pop_s   = 1'b1;
          tx_shift_d = tx_rdata_s;
          tx_timer_d = clkdiv_q;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX FSM state; line resets high asynchronously, discarding any partial frame
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_timer_q <= 16'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_timer_q <= tx_timer_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  // Two-flop synchroniser plus previous-value flop for start-edge detection
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], uart_rx};
      rx_prev_q <= sync_q[1];
    end
  end

  // RX FSM next state; returns to IDLE at the stop sample to catch a following start edge
  always_comb begin
    rx_state_d = rx_state_q;
    rx_timer_d = rx_timer_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push_s  = 1'b0;
    fe_evt_s   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_timer_d = half_s;
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_timer_q != 16'd0) begin
          rx_timer_d = rx_timer_q - 16'd1;
        end else if (rx_s) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_timer_d = clkdiv_q;
          rx_bit_d   = 3'd0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_timer_q == 16'd0) begin
          rx_timer_d = clkdiv_q;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_state_d = RX_DATA;
        end else begin
          rx_timer_d = rx_timer_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_timer_q != 16'd0) begin
          rx_timer_d = rx_timer_q - 16'd1;
        end else begin
          rx_push_s  = rx_s;
          fe_evt_s   = !rx_s;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX FSM state
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_timer_q <= 16'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_timer_q <= rx_timer_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

endmodule
